seg_scan_595: RTL and testbench
===============================

Name: seg_scan_595

Overview:
- Downstream consumer of the score path: takes the 2-digit BCD score plus the clear/start status pulses and drives a 6-digit common-anode 7-segment display through two cascaded 74HC595s.
- Time-multiplexes the digits: one 14-bit frame per digit per scan tick.
- Serialises each frame on ds/shcp, then latches it with stcp.

Parameters:
- SCAN_CNT_MAX, 24_999: scan-tick period minus 1, in clk_25m cycles (1 ms). Legal range ≥ 63, so a frame always completes before the next tick.
- NUM_DIGITS, 6: number of digit selects. Fixed at 6; the frame word is 14 bits.

Ports:
- clk_25m  in  1  system clock, 25 MHz
- rst_n  in  1  asynchronous, active-low reset
- bcd_data  in  8  score; [7:4] tens, [3:0] units
- clear_signal  in  1  1-cycle pulse; return to IDLE display
- start_signal  in  1  1-cycle pulse; enter RUN display
- stcp  out  1  595 storage (latch) clock
- shcp  out  1  595 shift clock
- ds  out  1  595 serial data
- oe  out  1  595 output enable, active low

Behaviour:
- Reset values: stcp=0, shcp=0, ds=0, oe=1; mode=IDLE; fsm=WAIT; digit index=0; scan counter=0.
- Mode register:
  - IDLE→RUN on start_signal.
  - RUN→IDLE on clear_signal.
  - clear_signal and start_signal in the same cycle: clear wins, mode=IDLE.
- Scan counter runs freely 0..SCAN_CNT_MAX and wraps. tick=1 on the cycle the count equals SCAN_CNT_MAX.
- FSM states: WAIT, SHIFT, LATCH.
  - WAIT→SHIFT on tick.
    - On this transition, snapshot bcd_data and mode into frame registers and build word W[13:0] = {seg[7:0], sel[5:0]}.
    - bcd_data changes during a frame have no effect on that frame.
  - SHIFT: 14 bits × 4 cycles = 56 cycles. Bit k = W[k], LSB first.
    - Phase 0: ds=W[k], shcp=0.
    - Phase 1: shcp=0.
    - Phase 2: shcp=1.
    - Phase 3: shcp=1.
    - After bit 13, phase 3 → LATCH; shcp returns to 0.
  - LATCH: 4 cycles.
    - stcp=1 in cycles 1 and 2, 0 otherwise.
    - At the end: digit index increments (5 wraps to 0), oe←0 permanently, → WAIT.
  - Latency: first ds valid on the cycle after tick. Frame length is 60 cycles.
- A tick that arrives outside WAIT is ignored. This cannot occur with a legal parameter.
- Digit select: sel one-hot, active high, sel[i]=1 for digit index i. Index 0 is the rightmost digit.
- Segment codes (active low, {dp,g..a}):
  - Digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Blank: FF.
  - Dash: BF.
  - Error 'E': 86.
- IDLE content: all 6 digits show dash.
- RUN content:
  - Digit 0 = units.
  - Digit 1 = tens, blanked when tens=0 (leading-zero suppression).
  - Digits 2-5 blank.
  - Any nibble >9 shows 'E'. An invalid tens nibble is never blanked.
- Reset mid-frame: all outputs return to reset values immediately and oe=1. Display resumes from digit 0 at the next tick.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - A 9-bit counter of scan ticks toggles blink_phase every 250 ticks (0.25 s); reset value 0.
  - In IDLE, frames snapshotted with blink_phase=1 use blank (FF) instead of dash.
  - RUN is unaffected. Entering RUN does not reset the blink counter.
- Undefined: IDLE dashes are steady; no blink counter is present.

Decomposition:
- Package seg_pkg holds:
  - Segment code constants: SEG_0..SEG_9, SEG_BLANK, SEG_DASH, SEG_E.
  - FSM state encoding: WAIT/SHIFT/LATCH.
  - Mode encoding: IDLE/RUN.
  - Frame width constant: 14.
  - Bits-per-frame and phase-count constants.
- One sub-module, hc595_shifter:
  - Inputs: 14-bit word, load strobe.
  - Outputs: ds, shcp, stcp, busy, done.
  - Contains the SHIFT/LATCH sequencing.
- The top holds the scan counter, mode register, digit index, code lookup and oe.

Test Plan (SCAN_CNT_MAX=99):
- Reset release, no start → oe=1 until the first LATCH ends. First frame W=14'b10111111_000001: stcp pulse at cycles 58-59 after tick. oe=0 from then on.
- start_signal pulse, bcd_data=8'h37 → digit0 frame seg=F8 sel=000001; digit1 frame seg=B0 sel=000010; digits 2-5 seg=FF.
- bcd_data=8'h05 in RUN → digit1 seg=FF, digit0 seg=92. bcd_data=8'h3A → digit0 seg=86.
- clear_signal and start_signal pulsed in the same cycle while in RUN → next frame seg=BF (IDLE).
- bcd_data changed mid-SHIFT → the current frame carries the old value; the next frame carries the new value.
- rst_n asserted at SHIFT bit 7 → stcp/shcp/ds=0 and oe=1 in the same cycle; after release, the first frame is digit 0 and its contents are correct.

Source files
------------

// File: rtl/seg_scan_595_pkg.sv
// Shared constants for the 74HC595 scanned 7-segment display: segment codes,
// shifter state encoding, display mode encoding and frame geometry.
package seg_pkg;

  localparam int FRAME_W        = 14;
  localparam int BITS_PER_FRAME = 14;
  localparam int PHASES_PER_BIT = 4;
  localparam int LATCH_CYCLES   = 4;

  // Active-low segment codes, bit order {dp, g, f, e, d, c, b, a}.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;

  typedef enum logic [1:0] {WAIT, SHIFT, LATCH} shift_state_e;
  typedef enum logic {IDLE, RUN} mode_e;

  // Nibbles above 9 are not BCD and render as 'E'.
  function automatic logic [7:0] seg_of_nibble(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_595_hc595_shifter.sv
// Serialises one 14-bit frame LSB first onto ds/shcp (4 clocks per bit), then
// pulses stcp to latch it into the cascaded 74HC595 pair.
module hc595_shifter
  import seg_pkg::*;
(
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] word,
  input  logic               load,
  output logic               ds,
  output logic               shcp,
  output logic               stcp,
  output logic               busy,
  output logic               done
);

  shift_state_e       state_q, state_d;
  logic [3:0]         bit_q, bit_d;
  logic [1:0]         phase_q, phase_d;
  logic [FRAME_W-1:0] word_q, word_d;
  logic               ds_q, ds_d;
  logic               shcp_q, shcp_d;
  logic               stcp_q, stcp_d;

  // NOTE: every always_comb output takes its default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    word_d  = word_q;
    case (state_q)
      WAIT: begin
        if (load) begin
          state_d = SHIFT;
          word_d  = word;
          bit_d   = '0;
          phase_d = '0;
        end
      end
      SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'(PHASES_PER_BIT - 1)) begin
          if (bit_q == 4'(BITS_PER_FRAME - 1)) begin
            state_d = LATCH;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      LATCH: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'(LATCH_CYCLES - 1)) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase

    // Pin values are derived from the next state so they leave a flop aligned with it.
    ds_d   = (state_d == SHIFT) ? word_d[bit_d] : 1'b0;
    shcp_d = (state_d == SHIFT) && phase_d[1];
    stcp_d = (state_d == LATCH) && (phase_d == 2'd1 || phase_d == 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      bit_q   <= '0;
      phase_q <= '0;
      word_q  <= '0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      word_q  <= word_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign busy = (state_q != WAIT);
  assign done = (state_q == LATCH) && (phase_q == 2'(LATCH_CYCLES - 1));

endmodule

// File: rtl/seg_scan_595.sv
// 6-digit multiplexed score display over two cascaded 74HC595s.
// Optional IDLE blink is built when SEG_BLINK_EN is defined.
module seg_scan_595
  import seg_pkg::*;
#(
  parameter int SCAN_CNT_MAX = 24_999,
  parameter int NUM_DIGITS   = 6
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic [7:0] bcd_data,
  input  logic       clear_signal,
  input  logic       start_signal,
  output logic       stcp,
  output logic       shcp,
  output logic       ds,
  output logic       oe
);

  localparam int CNT_W = $clog2(SCAN_CNT_MAX + 1);
  localparam int DIG_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
  mode_e                 mode_q, mode_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic                  oe_q, oe_d;
  logic                  tick;
  logic                  blank_idle;
  logic                  busy;
  logic                  done;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] sel;
  logic [FRAME_W-1:0]    frame_word;

  assign tick = (scan_cnt_q == CNT_W'(SCAN_CNT_MAX));

`ifdef SEG_BLINK_EN
  logic [8:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (blink_cnt_q == 9'd249) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank_idle = blink_phase_q;
`else
  assign blank_idle = 1'b0;
`endif

  always_comb begin
    scan_cnt_d = tick ? '0 : scan_cnt_q + CNT_W'(1);

    // Clear has priority when both pulses land in the same cycle.
    mode_d = mode_q;
    if (clear_signal)      mode_d = IDLE;
    else if (start_signal) mode_d = RUN;

    digit_d = digit_q;
    oe_d    = oe_q;
    if (done) begin
      digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
      oe_d    = 1'b0;
    end

    sel = NUM_DIGITS'(1) << digit_q;
    seg = SEG_BLANK;
    if (mode_q == IDLE) begin
      seg = blank_idle ? SEG_BLANK : SEG_DASH;
    end else if (digit_q == DIG_W'(0)) begin
      seg = seg_of_nibble(bcd_data[3:0]);
    end else if (digit_q == DIG_W'(1)) begin
      seg = (bcd_data[7:4] == 4'd0) ? SEG_BLANK : seg_of_nibble(bcd_data[7:4]);
    end
    frame_word = {seg, sel};
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      mode_q     <= IDLE;
      digit_q    <= '0;
      oe_q       <= 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      mode_q     <= mode_d;
      digit_q    <= digit_d;
      oe_q       <= oe_d;
    end
  end

  // The shifter captures frame_word on load, freezing bcd_data and mode for the frame.
  hc595_shifter u_shifter (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .word    (frame_word),
    .load    (tick && !busy),
    .ds      (ds),
    .shcp    (shcp),
    .stcp    (stcp),
    .busy    (busy),
    .done    (done)
  );

  assign oe = oe_q;

endmodule

// File: tb/tb_seg_scan_595.sv
// Scoreboard bench for seg_scan_595: expected frames are queued by the stimulus,
// a monitor rebuilds each frame from ds/shcp and compares it on every stcp pulse.
module tb_seg_scan_595;

  logic       clk_25m = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bcd_data = 8'h00;
  logic       clear_signal = 1'b0;
  logic       start_signal = 1'b0;
  logic       stcp, shcp, ds, oe;

  seg_scan_595 #(.SCAN_CNT_MAX(99), .NUM_DIGITS(6)) dut (
    .clk_25m      (clk_25m),
    .rst_n        (rst_n),
    .bcd_data     (bcd_data),
    .clear_signal (clear_signal),
    .start_signal (start_signal),
    .stcp         (stcp),
    .shcp         (shcp),
    .ds           (ds),
    .oe           (oe)
  );

  always #20 clk_25m = ~clk_25m;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle index since reset release; the first tick occurs in cycle 99.
  int cyc;
  always @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [13:0] exp_q[$];
  int          rd_idx = 0;
  int          frames_done = 0;
  bit          first_after_rst = 1'b1;
  int          nbits = 0;
  logic [13:0] mon_word = '0;
  logic        shcp_prev = 1'b0;
  logic        stcp_prev = 1'b0;

  always @(negedge clk_25m) begin
    if (!rst_n) begin
      nbits           = 0;
      mon_word        = '0;
      shcp_prev       = 1'b0;
      stcp_prev       = 1'b0;
      first_after_rst = 1'b1;
    end else begin
      if (first_after_rst && cyc == 159) check("oe_before_first_latch_end", oe, 1);
      if (first_after_rst && cyc == 160) begin
        check("oe_after_first_latch_end", oe, 0);
        first_after_rst = 1'b0;
      end
      if (shcp && !shcp_prev) begin
        if (nbits < 14) mon_word[nbits] = ds;
        nbits++;
      end
      if (first_after_rst && !stcp && stcp_prev) check("stcp_fall_cycle", cyc, 159);
      if (stcp && !stcp_prev) begin
        if (first_after_rst) check("stcp_rise_cycle", cyc, 157);
        check("frame_bit_count", nbits, 14);
        if (rd_idx >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %b, expected no frame", mon_word);
        end else begin
          check($sformatf("frame%0d", rd_idx), mon_word, exp_q[rd_idx]);
          rd_idx++;
        end
        nbits = 0;
        frames_done++;
      end
      shcp_prev = shcp;
      stcp_prev = stcp;
    end
  end

  task automatic push(input logic [7:0] seg, input int digit);
    logic [5:0] sel;
    sel = 6'b000001 << digit;
    exp_q.push_back({seg, sel});
  endtask

  task automatic wait_frame();
    int target;
    int n;
    target = frames_done + 1;
    n = 0;
    while (frames_done < target && n < 300) begin
      @(negedge clk_25m);
      n++;
    end
    check("frame_arrived", 32'(frames_done >= target), 1);
  endtask

  task automatic frame(input logic [7:0] seg, input int digit);
    push(seg, digit);
    wait_frame();
  endtask

  task automatic blank_2_to_5();
    for (int d = 2; d <= 5; d++) frame(8'hFF, d);
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    @(negedge clk_25m);
    while ((cyc % 100) != ph && n < 200) begin
      @(negedge clk_25m);
      n++;
    end
    check("phase_reached", cyc % 100, ph);
  endtask

  task automatic pulse(input logic clr, input logic st);
    clear_signal = clr;
    start_signal = st;
    @(negedge clk_25m);
    clear_signal = 1'b0;
    start_signal = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_25m);
    check("reset_stcp", stcp, 0);
    check("reset_shcp", shcp, 0);
    check("reset_ds", ds, 0);
    check("reset_oe", oe, 1);
    rst_n = 1'b1;

    // IDLE after reset: dash on digit 0, frame 14'b10111111_000001.
    frame(8'hBF, 0);

    bcd_data = 8'h37;
    pulse(1'b0, 1'b1);
    frame(8'hB0, 1);
    blank_2_to_5();
    frame(8'hF8, 0);

    bcd_data = 8'h05;
    frame(8'hFF, 1);
    blank_2_to_5();
    frame(8'h92, 0);

    bcd_data = 8'h3A;
    frame(8'hB0, 1);
    blank_2_to_5();
    frame(8'h86, 0);

    bcd_data = 8'hA0;
    frame(8'h86, 1);
    blank_2_to_5();
    frame(8'hC0, 0);

    // bcd_data changes during SHIFT: this frame keeps 7, the next shows tens 4.
    bcd_data = 8'h37;
    frame(8'hB0, 1);
    blank_2_to_5();
    push(8'hF8, 0);
    wait_phase(20);
    bcd_data = 8'h42;
    wait_frame();
    frame(8'h99, 1);

    pulse(1'b1, 1'b1);
    frame(8'hBF, 2);
    frame(8'hBF, 3);

    // Reset during digit 4, bit 7 phase 2 (shcp high, ds = BF bit 1 = 1).
    wait_phase(30);
    check("shcp_before_reset", shcp, 1);
    check("ds_before_reset", ds, 1);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_stcp", stcp, 0);
    check("midframe_rst_shcp", shcp, 0);
    check("midframe_rst_ds", ds, 0);
    check("midframe_rst_oe", oe, 1);
    repeat (3) @(negedge clk_25m);
    rst_n = 1'b1;

    frame(8'hBF, 0);
    bcd_data = 8'h19;
    pulse(1'b0, 1'b1);
    frame(8'hF9, 1);
    frame(8'hFF, 2);

    check("frames_consumed", rd_idx, exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
